tlb: RTL and testbench
======================

# tlb

Fully-associative translation lookaside buffer that sits directly upstream of the MMU page-table walker, one instance each for the I-side and D-side. It answers virtual-to-physical lookups from its pipeline client in the same cycle on a hit. On a miss it issues a single walk request to the MMU, installs the returned 4 KiB translation, and replays the lookup. The I-TLB drives MMU port 0 and the D-TLB drives MMU port 1.

## Interface
Parameters:
- ENTRIES, 8, number of fully-associative entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  client lookup request; client holds it and req_addr stable until resp_valid
- req_addr  in  64  virtual address
- req_access  in  2  0=read, 1=write, 2=exec, 3=reserved (treated as read)
- resp_valid  out  1  translation result valid this cycle
- resp_paddr  out  64  physical address
- resp_fault  out  1  permission fault; qualifies resp_valid
- flush  in  1  invalidate all entries (sfence.vma)
- mmu_req_valid  out  1  walk request to MMU reqN_valid
- mmu_req_addr  out  64  walk address to MMU reqN_addr
- mmu_resp_valid  in  1  MMU respN_valid
- mmu_resp_addr  in  64  MMU resp_data_addr; translated page base, bits [11:0] = 0
- mmu_resp_perms  in  8  MMU resp_data_perms {D,A,G,U,X,W,R,V}

## Operation
- Entry contents: valid bit, tag = vaddr[63:12], ppn = paddr[63:12], perms[7:0].
- Hit: req_valid, state IDLE, and some valid entry whose tag equals req_addr[63:12]. At most one entry can match.
- On a hit, resp_paddr = {ppn, req_addr[11:0]}.
- On a hit, resp_fault = !V, or (access==read && !R), or (access==write && !W), or (access==exec && !X).
- A/D/G/U bits are stored and not checked.
- States:
  - IDLE: on req_valid && !hit, latch req_addr[63:12] into walk_tag, clear discard, and go to MISS.
  - MISS: mmu_req_valid=1 and mmu_req_addr={walk_tag,12'b0}, held constant for the whole state. On mmu_resp_valid, install the entry unless discard is set, then return to IDLE. The lookup then hits on the following cycle.
- mmu_req_valid is exactly (state==MISS). It stays high during the MMU's response cycle; the MMU does not sample it there.
- Victim selection, in order:
  1. The lowest-index invalid entry.
  2. Otherwise, entry victim_ptr; victim_ptr then increments modulo ENTRIES.
- victim_ptr changes only when a valid entry is replaced.
- Flush clears all valid bits on the next edge.
  - In MISS, flush also sets discard. The walk cannot be cancelled, so the MMU response is still awaited and then dropped, with no install.
  - Flush in the same cycle as mmu_resp_valid also drops the fill.
  - Flush has priority over a same-cycle hit; that cycle's hit is still reported.
- If req_valid drops or req_addr changes during MISS, the walk completes and installs for walk_tag. The next lookup is evaluated fresh.

## Timing
- Reset values:
  - state=IDLE, all valid bits=0, victim_ptr=0, discard=0, walk_tag=0.
  - Hence resp_valid=0, resp_fault=0, resp_paddr=0, mmu_req_valid=0, mmu_req_addr=0.
- Hit latency: 0 cycles. resp_valid, resp_paddr and resp_fault are combinational from req_addr and the entry array.
- When resp_valid=0, resp_paddr and resp_fault are 0.
- Miss latency, with the miss detected at cycle 0:
  - mmu_req_valid rises at cycle 1.
  - The MMU responds at cycle 1+W.
  - The entry is written at that edge.
  - resp_valid occurs at cycle 2+W.
- resp_valid is never asserted in MISS.
- Reset asserted mid-walk returns to IDLE asynchronously. The MMU is expected to be reset by the same signal.

## Test plan
- Reset, then req_valid with req_addr=0x0000_1234_5678, read: miss, mmu_req_valid=1 with mmu_req_addr=0x0000_1234_5000. MMU returns 0x8000_0000 with perms 0x0F. resp_valid arrives the cycle after, with resp_paddr=0x8000_0678 and fault=0.
- Repeat the same page with offset 0x9AB: resp_valid in the same cycle with paddr 0x8000_09AB, and no MMU request.
- Install an entry with perms 0x03 (R only), then a write lookup to it: resp_valid=1 and resp_fault=1. An exec lookup also faults; a read lookup does not.
- Fill ENTRIES+1 distinct pages: the (ENTRIES+1)th replaces entry 0 and victim_ptr becomes 1. Page 0 then misses, page 1 hits.
- Start a miss, pulse flush before mmu_resp_valid: the response is accepted but nothing is installed. All pages then miss and the original lookup re-walks.
- Assert reset in MISS: mmu_req_valid falls immediately, resp_valid=0, and all entries are invalid afterwards.

Source files
------------

// File: rtl/tlb.sv
`default_nettype none
// ============================================================================
// Module   : tlb
// Purpose  : Fully-associative translation lookaside buffer placed in front of
//            the MMU page-table walker. A lookup that hits is answered in the
//            same cycle. A miss issues one walk request, installs the returned
//            4 KiB translation and lets the held lookup hit on the next cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1   clock
//   reset           in   1   asynchronous active-high reset
//   req_valid       in   1   client lookup request (held until resp_valid)
//   req_addr        in   64  virtual address
//   req_access      in   2   0=read 1=write 2=exec 3=read
//   resp_valid      out  1   translation result valid (combinational)
//   resp_paddr      out  64  physical address, 0 when resp_valid=0
//   resp_fault      out  1   permission fault, 0 when resp_valid=0
//   flush           in   1   invalidate all entries
//   mmu_req_valid   out  1   walk request to the MMU
//   mmu_req_addr    out  64  walk address (page aligned)
//   mmu_resp_valid  in   1   walk response valid
//   mmu_resp_addr   in   64  translated page base
//   mmu_resp_perms  in   8   {D,A,G,U,X,W,R,V}
// ============================================================================
module tlb #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_access,
  output logic        resp_valid,
  output logic [63:0] resp_paddr,
  output logic        resp_fault,
  input  logic        flush,
  output logic        mmu_req_valid,
  output logic [63:0] mmu_req_addr,
  input  logic        mmu_resp_valid,
  input  logic [63:0] mmu_resp_addr,
  input  logic [7:0]  mmu_resp_perms
);

  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;

  // Permission bit positions inside perms
  localparam int P_V = 0;
  localparam int P_R = 1;
  localparam int P_W = 2;
  localparam int P_X = 3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]         state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [51:0]        tag_q   [ENTRIES];
  logic [51:0]        tag_d   [ENTRIES];
  logic [51:0]        ppn_q   [ENTRIES];
  logic [51:0]        ppn_d   [ENTRIES];
  logic [7:0]         perms_q [ENTRIES];
  logic [7:0]         perms_d [ENTRIES];
  logic [IDXW-1:0]    victim_ptr_q, victim_ptr_d;
  logic               discard_q, discard_d;
  logic [51:0]        walk_tag_q, walk_tag_d;

  // --------------------------------------------------------------------------
  // Lookup
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] match;
  logic [51:0]        hit_ppn;
  logic [7:0]         hit_perms;
  logic               any_match;
  logic               lookup_hit;
  logic               perm_ok;
  logic               hit_fault;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
    assign match[gi] = valid_q[gi] && (tag_q[gi] == req_addr[63:12]);
  end

  // Tags are unique among valid entries, so match is one-hot or zero and an
  // OR-reduction acts as the read mux.
  always_comb begin
    hit_ppn   = '0;
    hit_perms = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match[i]) begin
        hit_ppn   = hit_ppn | ppn_q[i];
        hit_perms = hit_perms | perms_q[i];
      end
    end
  end

  assign any_match  = |match;
  assign lookup_hit = req_valid && (state_q == S_IDLE) && any_match;

  // Access type 3 is reserved and checked like a read.
  always_comb begin
    perm_ok = hit_perms[P_R];
    case (req_access)
      2'd1:    perm_ok = hit_perms[P_W];
      2'd2:    perm_ok = hit_perms[P_X];
      default: perm_ok = hit_perms[P_R];
    endcase
    hit_fault = !hit_perms[P_V] || !perm_ok;
  end

  // --------------------------------------------------------------------------
  // Victim selection: lowest-index free slot, else round-robin pointer
  // --------------------------------------------------------------------------
  logic            any_invalid;
  logic [IDXW-1:0] free_idx;
  logic [IDXW-1:0] victim_idx;
  logic            fill_en;

  assign any_invalid = ~&valid_q;

  // Scanning downward leaves the lowest invalid index as the final value.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDXW'(i);
      end
    end
  end

  assign victim_idx = any_invalid ? free_idx : victim_ptr_q;

  // A fill is dropped if a flush was seen during the walk or arrives with it.
  assign fill_en = (state_q == S_MISS) && mmu_resp_valid && !discard_q && !flush;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !lookup_hit) begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        // The walk cannot be cancelled; always wait for its response.
        if (mmu_resp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    resp_valid    = lookup_hit;
    resp_paddr    = lookup_hit ? {hit_ppn, req_addr[11:0]} : 64'd0;
    resp_fault    = lookup_hit && hit_fault;
    mmu_req_valid = (state_q == S_MISS);
    mmu_req_addr  = (state_q == S_MISS) ? {walk_tag_q, 12'h000} : 64'd0;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state: walk bookkeeping, fills, flush
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    ppn_d        = ppn_q;
    perms_d      = perms_q;
    victim_ptr_d = victim_ptr_q;
    discard_d    = discard_q;
    walk_tag_d   = walk_tag_q;

    if ((state_q == S_IDLE) && req_valid && !lookup_hit) begin
      walk_tag_d = req_addr[63:12];
      discard_d  = 1'b0;
    end

    if ((state_q == S_MISS) && flush) begin
      discard_d = 1'b1;
    end

    if (fill_en) begin
      valid_d[victim_idx] = 1'b1;
      tag_d[victim_idx]   = walk_tag_q;
      ppn_d[victim_idx]   = mmu_resp_addr[63:12];
      perms_d[victim_idx] = mmu_resp_perms;
      // The pointer only advances when a live translation is evicted.
      if (!any_invalid) begin
        victim_ptr_d = victim_ptr_q + IDXW'(1);
      end
    end

    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      victim_ptr_q <= '0;
      discard_q    <= 1'b0;
      walk_tag_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]   <= '0;
        ppn_q[i]   <= '0;
        perms_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      victim_ptr_q <= victim_ptr_d;
      discard_q    <= discard_d;
      walk_tag_q   <= walk_tag_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]   <= tag_d[i];
        ppn_q[i]   <= ppn_d[i];
        perms_q[i] <= perms_d[i];
      end
    end
  end

  // Page-offset bits of the walk result and the D/A/G/U bits are not consumed.
  logic unused_bits;
  assign unused_bits = ^{mmu_resp_addr[11:0], hit_perms[7:4]};

endmodule
`default_nettype wire

// File: tb/tb_tlb.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb
// Purpose  : Directed self-checking bench for tlb (ENTRIES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_access;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic        resp_fault;
  logic        flush;
  logic        mmu_req_valid;
  logic [63:0] mmu_req_addr;
  logic        mmu_resp_valid;
  logic [63:0] mmu_resp_addr;
  logic [7:0]  mmu_resp_perms;

  int checks = 0;
  int errors = 0;

  tlb #(.ENTRIES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_access     (req_access),
    .resp_valid     (resp_valid),
    .resp_paddr     (resp_paddr),
    .resp_fault     (resp_fault),
    .flush          (flush),
    .mmu_req_valid  (mmu_req_valid),
    .mmu_req_addr   (mmu_req_addr),
    .mmu_resp_valid (mmu_resp_valid),
    .mmu_resp_addr  (mmu_resp_addr),
    .mmu_resp_perms (mmu_resp_perms)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a lookup at a falling edge and settle before the next rising edge.
  task automatic probe(input logic [63:0] va, input logic [1:0] acc);
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = va;
    req_access = acc;
    #1;
  endtask

  // Drive a lookup that is expected to miss, act as the MMU with W wait
  // cycles, and return what was observed. Ends one cycle after the response
  // with the lookup still held so the caller can check the replayed hit.
  task automatic run_fill(input logic [63:0] va, input logic [1:0] acc,
                          input logic [63:0] pa, input logic [7:0] perms,
                          input int w, output logic first_resp,
                          output logic req_ok, output logic [63:0] req_seen);
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = va;
    req_access = acc;
    #1;
    first_resp = resp_valid;
    @(negedge clk);
    #1;
    req_ok   = mmu_req_valid && !resp_valid;
    req_seen = mmu_req_addr;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      #1;
      req_ok = req_ok && mmu_req_valid && !resp_valid && (mmu_req_addr == req_seen);
    end
    mmu_resp_valid = 1'b1;
    mmu_resp_addr  = pa;
    mmu_resp_perms = perms;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    mmu_resp_addr  = '0;
    mmu_resp_perms = '0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_paddr !== 64'd0) begin errors++; $display("FAIL reset_resp_paddr: got %h want 0", resp_paddr); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reset_resp_fault: got %b want 0", resp_fault); end
    checks++; if (mmu_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mmu_req_valid: got %b want 0", mmu_req_valid); end
    checks++; if (mmu_req_addr !== 64'd0) begin errors++; $display("FAIL reset_mmu_req_addr: got %h want 0", mmu_req_addr); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_miss_fill;
    logic fr, ok;
    logic [63:0] ra;
    run_fill(64'h0000_0000_1234_5678, 2'd0, 64'h0000_0000_8000_0000, 8'h0F, 2, fr, ok, ra);
    checks++; if (fr !== 1'b0) begin errors++; $display("FAIL miss_no_resp: got %b want 0", fr); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL miss_req_held: got %b want 1", ok); end
    checks++; if (ra !== 64'h0000_0000_1234_5000) begin errors++; $display("FAIL miss_req_addr: got %h want 0000000012345000", ra); end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL fill_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_paddr !== 64'h0000_0000_8000_0678) begin errors++; $display("FAIL fill_paddr: got %h want 0000000080000678", resp_paddr); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL fill_fault: got %b want 0", resp_fault); end
    checks++; if (mmu_req_valid !== 1'b0) begin errors++; $display("FAIL fill_mmu_req_drop: got %b want 0", mmu_req_valid); end
  endtask

  task automatic test_hit;
    probe(64'h0000_0000_1234_59AB, 2'd0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hit_valid: got %b want 1", resp_valid); end
    checks++; if (resp_paddr !== 64'h0000_0000_8000_09AB) begin errors++; $display("FAIL hit_paddr: got %h want 00000000800009ab", resp_paddr); end
    @(negedge clk);
    #1;
    checks++; if (mmu_req_valid !== 1'b0) begin errors++; $display("FAIL hit_no_walk: got %b want 0", mmu_req_valid); end
  endtask

  task automatic test_fault;
    logic fr, ok;
    logic [63:0] ra;
    run_fill(64'h0000_0000_2000_3000, 2'd0, 64'h0000_0000_9000_0000, 8'h03, 0, fr, ok, ra);
    checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0) begin errors++; $display("FAIL ronly_read_fill: got valid=%b fault=%b want 1/0", resp_valid, resp_fault); end
    probe(64'h0000_0000_2000_3ABC, 2'd1);
    checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1) begin errors++; $display("FAIL ronly_write: got valid=%b fault=%b want 1/1", resp_valid, resp_fault); end
    checks++; if (resp_paddr !== 64'h0000_0000_9000_0ABC) begin errors++; $display("FAIL ronly_paddr: got %h want 0000000090000abc", resp_paddr); end
    probe(64'h0000_0000_2000_3ABC, 2'd2);
    checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL ronly_exec: got %b want 1", resp_fault); end
    probe(64'h0000_0000_2000_3ABC, 2'd0);
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL ronly_read: got %b want 0", resp_fault); end
    probe(64'h0000_0000_2000_3ABC, 2'd3);
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL ronly_reserved: got %b want 0", resp_fault); end
    // V clear with R/W/X set: every access faults.
    run_fill(64'h0000_0000_2000_4010, 2'd0, 64'h0000_0000_9000_1000, 8'h0E, 1, fr, ok, ra);
    checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1) begin errors++; $display("FAIL novalid_read: got valid=%b fault=%b want 1/1", resp_valid, resp_fault); end
    probe(64'h0000_0000_2000_4010, 2'd1);
    checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL novalid_write: got %b want 1", resp_fault); end
  endtask

  task automatic test_replacement;
    logic fr, ok;
    logic [63:0] ra;
    int miss_bad;
    int hit_bad;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    // Page 0 was live before the flush; every one of the nine must miss.
    miss_bad = 0;
    hit_bad  = 0;
    for (int k = 0; k < 9; k++) begin
      run_fill(64'h0000_0000_1234_5000 + (64'(k) << 12), 2'd0,
               64'h0000_0000_A000_0000 + (64'(k) << 12), 8'h0F, 0, fr, ok, ra);
      if (fr !== 1'b0 || ok !== 1'b1) miss_bad++;
      if (resp_valid !== 1'b1 || resp_paddr !== 64'h0000_0000_A000_0000 + (64'(k) << 12)) hit_bad++;
    end
    checks++; if (miss_bad != 0) begin errors++; $display("FAIL repl_all_miss: got %0d bad fills want 0", miss_bad); end
    checks++; if (hit_bad != 0) begin errors++; $display("FAIL repl_all_replay: got %0d bad replays want 0", hit_bad); end
    probe(64'h0000_0000_1234_6000, 2'd0);
    checks++; if (resp_valid !== 1'b1 || resp_paddr !== 64'h0000_0000_A000_1000) begin errors++; $display("FAIL repl_page1_hit: got valid=%b paddr=%h want 1/a0001000", resp_valid, resp_paddr); end
    probe(64'h0000_0000_1234_D000, 2'd0);
    checks++; if (resp_valid !== 1'b1 || resp_paddr !== 64'h0000_0000_A000_8000) begin errors++; $display("FAIL repl_page8_hit: got valid=%b paddr=%h want 1/a0008000", resp_valid, resp_paddr); end
    // Page 0 was evicted; its refill goes to entry 1 (page 1) as victim_ptr=1.
    run_fill(64'h0000_0000_1234_5000, 2'd0, 64'h0000_0000_A000_0000, 8'h0F, 0, fr, ok, ra);
    checks++; if (fr !== 1'b0) begin errors++; $display("FAIL repl_page0_miss: got %b want 0", fr); end
    probe(64'h0000_0000_1234_7000, 2'd0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL repl_page2_kept: got %b want 1", resp_valid); end
    run_fill(64'h0000_0000_1234_6000, 2'd0, 64'h0000_0000_A000_1000, 8'h0F, 0, fr, ok, ra);
    checks++; if (fr !== 1'b0) begin errors++; $display("FAIL repl_page1_evicted: got %b want 0", fr); end
    probe(64'h0000_0000_1234_8000, 2'd0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL repl_page3_kept: got %b want 1", resp_valid); end
  endtask

  task automatic test_flush;
    // Flush while the walk is outstanding: response is swallowed.
    probe(64'h0000_0000_0BAD_C123, 2'd0);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flushA_miss: got %b want 0", resp_valid); end
    @(negedge clk);
    #1;
    checks++; if (mmu_req_valid !== 1'b1) begin errors++; $display("FAIL flushA_req: got %b want 1", mmu_req_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (mmu_req_valid !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL flushA_wait: got req=%b resp=%b want 1/0", mmu_req_valid, resp_valid); end
    mmu_resp_valid = 1'b1;
    mmu_resp_addr  = 64'h0000_0000_C000_0000;
    mmu_resp_perms = 8'h0F;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || mmu_req_valid !== 1'b0) begin errors++; $display("FAIL flushA_dropped: got resp=%b req=%b want 0/0", resp_valid, mmu_req_valid); end
    @(negedge clk);
    #1;
    checks++; if (mmu_req_valid !== 1'b1 || mmu_req_addr !== 64'h0000_0000_0BAD_C000) begin errors++; $display("FAIL flushA_rewalk: got req=%b addr=%h want 1/000000000badc000", mmu_req_valid, mmu_req_addr); end
    mmu_resp_valid = 1'b1;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_paddr !== 64'h0000_0000_C000_0123) begin errors++; $display("FAIL flushA_refill: got valid=%b paddr=%h want 1/c0000123", resp_valid, resp_paddr); end

    // Flush coincident with the MMU response also drops the fill.
    probe(64'h0000_0000_0BAD_D456, 2'd0);
    @(negedge clk);
    #1;
    mmu_resp_valid = 1'b1;
    mmu_resp_addr  = 64'h0000_0000_C000_1000;
    flush          = 1'b1;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    flush          = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flushB_dropped: got %b want 0", resp_valid); end
    @(negedge clk);
    #1;
    checks++; if (mmu_req_valid !== 1'b1) begin errors++; $display("FAIL flushB_rewalk: got %b want 1", mmu_req_valid); end
    mmu_resp_valid = 1'b1;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_paddr !== 64'h0000_0000_C000_1456) begin errors++; $display("FAIL flushB_refill: got valid=%b paddr=%h want 1/c0001456", resp_valid, resp_paddr); end

    // Flush alongside a hit: hit reported now, entry gone next cycle.
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL flushC_hit_kept: got %b want 1", resp_valid); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flushC_gone: got %b want 0", resp_valid); end
    @(negedge clk);
    #1;
    mmu_resp_valid = 1'b1;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    mmu_resp_addr  = '0;
    mmu_resp_perms = '0;
    #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL flushC_refill: got %b want 1", resp_valid); end
  endtask

  task automatic test_reset_mid_walk;
    logic fr, ok;
    logic [63:0] ra;
    probe(64'h0000_0000_0BAD_E000, 2'd0);
    @(negedge clk);
    #1;
    checks++; if (mmu_req_valid !== 1'b1) begin errors++; $display("FAIL rstwalk_in_miss: got %b want 1", mmu_req_valid); end
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    checks++; if (mmu_req_valid !== 1'b0 || mmu_req_addr !== 64'd0) begin errors++; $display("FAIL rstwalk_req_drop: got req=%b addr=%h want 0/0", mmu_req_valid, mmu_req_addr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstwalk_resp: got %b want 0", resp_valid); end
    @(negedge clk);
    reset = 1'b0;
    // This page was installed before reset and must now miss.
    run_fill(64'h0000_0000_0BAD_D456, 2'd0, 64'h0000_0000_C000_1000, 8'h0F, 0, fr, ok, ra);
    checks++; if (fr !== 1'b0 || ok !== 1'b1) begin errors++; $display("FAIL rstwalk_entries_cleared: got resp=%b req=%b want 0/1", fr, ok); end
    checks++; if (resp_valid !== 1'b1 || resp_paddr !== 64'h0000_0000_C000_1456) begin errors++; $display("FAIL rstwalk_refill: got valid=%b paddr=%h want 1/c0001456", resp_valid, resp_paddr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_access     = 2'd0;
    flush          = 1'b0;
    mmu_resp_valid = 1'b0;
    mmu_resp_addr  = '0;
    mmu_resp_perms = '0;
    test_reset();
    test_miss_fill();
    test_hit();
    test_fault();
    test_replacement();
    test_flush();
    test_reset_mid_walk();
    @(negedge clk);
    req_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
